// File: rtl/io_pad_ctrl.sv
// Multi-channel bidirectional pad slice: registered push-pull/open-drain drive, synchronized glitch-filtered input, edge pulses.
// Latency: core->pad 1 cycle; pad->core_out SYNC_STAGES+filt_len+1 cycles.
// Backpressure: none; every input is sampled every cycle.
module io_pad_ctrl #(
    parameter int IOPUT_NUM   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IOPUT_NUM-1:0] core_in,
    input  logic [IOPUT_NUM-1:0] core_oe,
    input  logic [IOPUT_NUM-1:0] mode_od,
    input  logic [FILT_W-1:0]    filt_len,
    output logic [IOPUT_NUM-1:0] core_out,
    output logic [IOPUT_NUM-1:0] rise_evt,
    output logic [IOPUT_NUM-1:0] fall_evt,
    inout  wire  [IOPUT_NUM-1:0] io_inout
);

    logic [IOPUT_NUM-1:0] out_q;
    logic [IOPUT_NUM-1:0] oe_q;
    logic [IOPUT_NUM-1:0] filt_q;
    logic [IOPUT_NUM-1:0] rise_q;
    logic [IOPUT_NUM-1:0] fall_q;
    logic [IOPUT_NUM-1:0] pad_val;
    logic [IOPUT_NUM-1:0] sync_s;
    logic [IOPUT_NUM-1:0] sync_q [SYNC_STAGES];
    logic [FILT_W-1:0]    cnt_q  [IOPUT_NUM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            oe_q  <= '0;
        end else begin
            out_q <= core_in;
            oe_q  <= core_oe;
        end
    end

    // Open-drain suppresses only the drive-high case; mode_od is used unregistered.
    for (genvar g = 0; g < IOPUT_NUM; g++) begin : g_pad
        assign io_inout[g] = (oe_q[g] && !(mode_od[g] && out_q[g])) ? out_q[g] : 1'bz;
    end

    assign pad_val = io_inout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= pad_val;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // ">=" lets a lowered filt_len accept a long-pending mismatch on the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < IOPUT_NUM; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < IOPUT_NUM; i++) begin
                if (sync_s[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= filt_len) begin
                    filt_q[i] <= sync_s[i];
                    cnt_q[i]  <= '0;
                    rise_q[i] <= sync_s[i];
                    fall_q[i] <= !sync_s[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign core_out = filt_q;
    assign rise_evt = rise_q;
    assign fall_evt = fall_q;

endmodule

// File: tb/tb_io_pad_ctrl.sv
// Bench for io_pad_ctrl: direct checks on the drive path, scoreboard of predicted filter events on the input path.
module tb_io_pad_ctrl;
    localparam int N    = 8;
    localparam int SYNC = 2;
    localparam int FW   = 4;

    typedef struct packed {
        int   cyc;
        logic dir;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  core_in, core_oe, mode_od;
    logic [FW-1:0] filt_len;
    logic [N-1:0]  core_out, rise_evt, fall_evt;
    tri1  [N-1:0]  io_pad;
    logic          ext_en;
    logic [N-1:0]  ext_val;

    assign io_pad = ext_en ? ext_val : {N{1'bz}};

    io_pad_ctrl #(.IOPUT_NUM(N), .SYNC_STAGES(SYNC), .FILT_W(FW)) dut (
        .clk      (clk),
        .rst      (rst),
        .core_in  (core_in),
        .core_oe  (core_oe),
        .mode_od  (mode_od),
        .filt_len (filt_len),
        .core_out (core_out),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt),
        .io_inout (io_pad)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: per-channel queues of predicted filtered transitions.
    exp_t         exp_q [N][$];
    exp_t         e;
    logic [N-1:0] model_out, er, ef;
    bit           mon_on = 1'b0;
    int           evt_pushed = 0;
    int           evt_seen   = 0;

    // Predictor: a run of L+1 consecutive samples differing from the filtered value is accepted.
    logic [N-1:0] lv, pf;
    int           rs [N];
    int           rl [N];
    int           pred_l = 0;
    bit           pred_on = 1'b0;

    task automatic push(input int ch, input int c, input logic d);
        exp_q[ch].push_back('{cyc: c, dir: d});
        evt_pushed++;
    endtask

    task automatic drive(input logic [N-1:0] v);
        @(negedge clk);
        ext_val = v;
        for (int i = 0; i < N; i++) begin
            if (v[i] != lv[i]) begin
                lv[i] = v[i];
                rs[i] = cyc;
                rl[i] = 1;
            end else if (rl[i] < 1000) begin
                rl[i]++;
            end
            if (pred_on && rl[i] == pred_l + 1 && lv[i] != pf[i]) begin
                pf[i] = lv[i];
                push(i, rs[i] + SYNC + pred_l + 1, lv[i]);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            er = '0;
            ef = '0;
            for (int i = 0; i < N; i++) begin
                while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) begin
                    check("evt_late", cyc, exp_q[i][0].cyc);
                    e = exp_q[i].pop_front();
                end
                if (exp_q[i].size() > 0 && exp_q[i][0].cyc == cyc) begin
                    e = exp_q[i].pop_front();
                    if (e.dir) er[i] = 1'b1;
                    else       ef[i] = 1'b1;
                    model_out[i] = e.dir;
                end
            end
            check("rise_evt", rise_evt, er);
            check("fall_evt", fall_evt, ef);
            check("core_out", core_out, model_out);
            check("evt_overlap", rise_evt & fall_evt, 0);
            evt_seen += $countones(rise_evt | fall_evt);
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [N-1:0] v;
        int c;
        rst = 1'b1; core_in = '0; core_oe = '0; mode_od = '0; filt_len = '0;
        ext_en = 1'b0; ext_val = '0;
        lv = '0; pf = '0; model_out = '0;
        for (int i = 0; i < N; i++) begin
            rs[i] = 0;
            rl[i] = 1000;
        end

        repeat (2) @(negedge clk);
        check("rst_core_out", core_out, 0);
        check("rst_evts", rise_evt | fall_evt, 0);
        check("rst_pads_z", io_pad, 8'hFF);

        // Push-pull drive with one-cycle latency, then loopback into the input path.
        @(negedge clk);
        rst = 1'b0; core_oe = 8'hFF; core_in = 8'hA5;
        #1 check("pp_before_edge", io_pad, 8'hFF);
        @(posedge clk); #1 check("pp_drive", io_pad, 8'hA5);
        repeat (5) @(posedge clk);
        #1 check("loopback", core_out, 8'hA5);
        #2 rst = 1'b1;
        #1 check("arst_pads_z", io_pad, 8'hFF);
        check("arst_core_out", core_out, 0);
        check("arst_evts", rise_evt | fall_evt, 0);

        // Pads stay released until the first edge after reset latches core_oe.
        @(negedge clk);
        core_in = 8'h00; rst = 1'b0;
        #1 check("rel_pads_z", io_pad, 8'hFF);
        @(posedge clk); #1 check("rel_drive", io_pad, 8'h00);

        // Open-drain: only lows are driven; an external low must win on every channel.
        @(negedge clk);
        mode_od = 8'hFF; core_in = 8'hF0;
        @(posedge clk); #1 check("od_pullup", io_pad, 8'hF0);
        @(negedge clk);
        core_in = 8'hFF; ext_val = 8'h00; ext_en = 1'b1;
        @(posedge clk); #1 check("od_no_drive1", io_pad, 8'h00);

        // Clean restart for the input path, pads driven only by the bench.
        @(negedge clk);
        core_oe = '0; core_in = '0; mode_od = '0; ext_val = '0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; model_out = '0; mon_on = 1'b1; pred_on = 1'b1;

        // L=0: single-cycle qualify on pad0.
        pred_l = 0; filt_len = 4'd0;
        repeat (6) drive(8'h01);
        repeat (6) drive(8'h00);

        // L=3: 3-cycle glitch rejected, 4-cycle pulse accepted on pad1.
        pred_l = 3; filt_len = 4'd3;
        repeat (3)  drive(8'h02);
        repeat (6)  drive(8'h00);
        repeat (4)  drive(8'h02);
        repeat (10) drive(8'h00);

        // L=7 lowered to 2 after 5 mismatching samples on pad2: accept on the next edge.
        pred_on = 1'b0; pred_l = 7; filt_len = 4'd7;
        drive(8'h04);
        c = cyc;
        repeat (7) drive(8'h04);
        filt_len = 4'd2;
        pred_l = 2;
        pf[2] = 1'b1;
        push(2, c + SYNC + 5 + 1, 1'b1);
        repeat (4) drive(8'h04);
        pred_on = 1'b1;
        repeat (8) drive(8'h00);

        // L=1: every channel with its own run length.
        pred_l = 1; filt_len = 4'd1;
        for (int t = 0; t < 48; t++) begin
            for (int ch = 0; ch < N; ch++) begin
                v[ch] = (((t + ch) / (ch + 1)) % 2) != 0;
            end
            drive(v);
        end
        repeat (8) drive(8'h00);
        repeat (2) @(posedge clk);
        #3 mon_on = 1'b0;

        for (int i = 0; i < N; i++) begin
            check("evt_pending", exp_q[i].size(), 0);
        end
        check("evt_count", evt_seen, evt_pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
